// File: rtl/mask_share_pkg.sv
// Shared definitions for the boolean-masking unit: op codes, FSM states,
// LFSR feedback polynomials and the share-lane slicing helper.
package mask_share_pkg;

  localparam logic [1:0] MASK_OP_MASK   = 2'b00;
  localparam logic [1:0] MASK_OP_REMASK = 2'b01;
  localparam logic [1:0] MASK_OP_UNMASK = 2'b10;

  localparam logic [63:0] MASK_POLY32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] MASK_POLY64 = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_GEN  = 2'd1,
    MS_DONE = 2'd2
  } mask_state_e;

  // Bit offset of share lane idx in a packed share vector.
  function automatic int unsigned share_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mask_share_lfsr.sv
// Reseedable Galois LFSR supplying one fresh mask word per step.
// A zero seed is loaded as 1 so the register can never lock up.
module mask_share_lfsr
  import mask_share_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = XLEN'(32'h0000_0001)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  input  logic            load,
  input  logic [XLEN-1:0] seed,
  output logic [XLEN-1:0] value,
  output logic [XLEN-1:0] next_value
);

  localparam logic [XLEN-1:0] POLY = (XLEN == 64) ? XLEN'(MASK_POLY64) : XLEN'(MASK_POLY32);

  // Galois shift: right shift, fold the polynomial in when the LSB falls out.
  always_comb begin
    next_value = (value >> 1) ^ (value[0] ? POLY : '0);
  end

  // State update: reseed has priority over stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= (seed == '0) ? XLEN'(1) : seed;
    end else if (step) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/mask_share_unit.sv
// Multi-cycle NSHARES-way boolean masking unit (MASK / REMASK / UNMASK).
// Optional trace port of the applied randomness: define MASK_SHARE_RVFI_EN.
module mask_share_unit
  import mask_share_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     NSHARES    = 2,
  parameter logic [XLEN-1:0] PRNG_RESET = XLEN'(32'h0000_0001)
) (
  input  logic                    g_clk,
  input  logic                    g_reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [XLEN*NSHARES-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN*NSHARES-1:0] rsp_data,
  output logic                    rsp_error,
  input  logic                    prng_seed_valid,
  input  logic [XLEN-1:0]         prng_seed
`ifdef MASK_SHARE_RVFI_EN
  ,
  output logic [XLEN*(NSHARES-1)-1:0] rvfi_mask_data
`endif
);

  localparam int unsigned DW    = XLEN * NSHARES;
  localparam int unsigned CNT_W = 2;

  mask_state_e        state_q, state_d;
  logic [DW-1:0]      data_q, data_d;
  logic [1:0]         op_q, op_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    rnd;
  logic [XLEN-1:0]    lfsr_value;
  logic [XLEN-1:0]    unmask_acc;
`ifdef MASK_SHARE_RVFI_EN
  logic [XLEN*(NSHARES-1)-1:0] rvfi_q, rvfi_d;
`endif

  mask_share_lfsr #(
    .XLEN      (XLEN),
    .RESET_VAL (PRNG_RESET)
  ) u_lfsr (
    .clk        (g_clk),
    .reset      (g_reset),
    .step       (state_q == MS_GEN),
    .load       (prng_seed_valid),
    .seed       (prng_seed),
    .value      (lfsr_value),
    .next_value (rnd)
  );

  // Next-state and datapath: accept, per-cycle share refresh, response hold.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    op_d       = op_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    unmask_acc = '0;
`ifdef MASK_SHARE_RVFI_EN
    rvfi_d     = rvfi_q;
`endif
    for (int unsigned i = 0; i < NSHARES; i++) begin
      unmask_acc = unmask_acc ^ req_data[share_lsb(i, XLEN) +: XLEN];
    end
    case (state_q)
      MS_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          cnt_d = '0;
          err_d = 1'b0;
          data_d = '0;
`ifdef MASK_SHARE_RVFI_EN
          rvfi_d = '0;
`endif
          case (req_op)
            MASK_OP_MASK: begin
              data_d[XLEN-1:0] = req_data[XLEN-1:0];
              state_d          = MS_GEN;
            end
            MASK_OP_REMASK: begin
              data_d  = req_data;
              state_d = MS_GEN;
            end
            MASK_OP_UNMASK: begin
              data_d[XLEN-1:0] = unmask_acc;
              state_d          = MS_DONE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = MS_DONE;
            end
          endcase
        end
      end
      MS_GEN: begin
        // A concurrent reseed stalls this step; the next cycle uses the new seed.
        if (!prng_seed_valid) begin
          for (int unsigned k = 1; k < NSHARES; k++) begin
            if (cnt_q == CNT_W'(k - 1)) begin
              if (op_q == MASK_OP_REMASK) begin
                data_d[share_lsb(k, XLEN) +: XLEN] = data_q[share_lsb(k, XLEN) +: XLEN] ^ rnd;
              end else begin
                data_d[share_lsb(k, XLEN) +: XLEN] = rnd;
              end
`ifdef MASK_SHARE_RVFI_EN
              rvfi_d[share_lsb(k - 1, XLEN) +: XLEN] = rnd;
`endif
            end
          end
          data_d[XLEN-1:0] = data_q[XLEN-1:0] ^ rnd;
          if (cnt_q == CNT_W'(NSHARES - 2)) begin
            state_d = MS_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      MS_DONE: begin
        if (rsp_ready) begin
          state_d = MS_IDLE;
        end
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= MS_IDLE;
      data_q  <= '0;
      op_q    <= MASK_OP_MASK;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MASK_SHARE_RVFI_EN
      rvfi_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef MASK_SHARE_RVFI_EN
      rvfi_q  <= rvfi_d;
`endif
    end
  end

  assign req_ready = (state_q == MS_IDLE);
  assign rsp_valid = (state_q == MS_DONE);
  assign rsp_data  = data_q;
  assign rsp_error = err_q;
`ifdef MASK_SHARE_RVFI_EN
  assign rvfi_mask_data = rvfi_q;
`endif

endmodule

// File: tb/tb_mask_share_unit.sv
// Directed bench for mask_share_unit: a 2-share and a 4-share instance, XLEN=32.
module tb_mask_share_unit;

  logic g_clk = 1'b0;
  logic g_reset;

  logic        req_valid2, req_ready2, rsp_valid2, rsp_ready2, rsp_error2, seed_valid2;
  logic [1:0]  req_op2;
  logic [63:0] req_data2, rsp_data2;
  logic [31:0] seed2;

  logic         req_valid4, req_ready4, rsp_valid4, rsp_ready4, rsp_error4, seed_valid4;
  logic [1:0]   req_op4;
  logic [127:0] req_data4, rsp_data4;
  logic [31:0]  seed4;

`ifdef MASK_SHARE_RVFI_EN
  logic [31:0] rvfi2;
  logic [95:0] rvfi4;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 g_clk = ~g_clk;

  mask_share_unit #(.XLEN(32), .NSHARES(2)) dut2 (
    .g_clk           (g_clk),
    .g_reset         (g_reset),
    .req_valid       (req_valid2),
    .req_ready       (req_ready2),
    .req_op          (req_op2),
    .req_data        (req_data2),
    .rsp_valid       (rsp_valid2),
    .rsp_ready       (rsp_ready2),
    .rsp_data        (rsp_data2),
    .rsp_error       (rsp_error2),
    .prng_seed_valid (seed_valid2),
    .prng_seed       (seed2)
`ifdef MASK_SHARE_RVFI_EN
    ,
    .rvfi_mask_data  (rvfi2)
`endif
  );

  mask_share_unit #(.XLEN(32), .NSHARES(4)) dut4 (
    .g_clk           (g_clk),
    .g_reset         (g_reset),
    .req_valid       (req_valid4),
    .req_ready       (req_ready4),
    .req_op          (req_op4),
    .req_data        (req_data4),
    .rsp_valid       (rsp_valid4),
    .rsp_ready       (rsp_ready4),
    .rsp_data        (rsp_data4),
    .rsp_error       (rsp_error4),
    .prng_seed_valid (seed_valid4),
    .prng_seed       (seed4)
`ifdef MASK_SHARE_RVFI_EN
    ,
    .rvfi_mask_data  (rvfi4)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // Present one request to the 2-share instance for exactly one accepting edge.
  task automatic issue2(input logic [1:0] op, input logic [63:0] data);
    req_valid2 = 1'b1;
    req_op2    = op;
    req_data2  = data;
    step();
    req_valid2 = 1'b0;
  endtask

  initial begin
    logic [31:0] x;
    g_reset = 1'b1;
    req_valid2 = 1'b0; req_op2 = 2'b00; req_data2 = '0; rsp_ready2 = 1'b1;
    seed_valid2 = 1'b0; seed2 = '0;
    req_valid4 = 1'b0; req_op4 = 2'b00; req_data4 = '0; rsp_ready4 = 1'b1;
    seed_valid4 = 1'b0; seed4 = '0;
    step();
    step();
    check("reset_rsp_valid", 128'(rsp_valid2), 128'd0);
    check("reset_rsp_error", 128'(rsp_error2), 128'd0);
    check("reset_rsp_data",  128'(rsp_data2),  128'd0);
    check("reset_req_ready", 128'(req_ready2), 128'd1);
    check("reset_req_ready4", 128'(req_ready4), 128'd1);
    g_reset = 1'b0;
    step();

    // MASK, seed 1: r1 = 0x80200003; upper lane is junk and must be ignored.
    issue2(2'b00, 64'hDEAD_BEEF_1234_5678);
    check("mask_t1_not_valid", 128'(rsp_valid2), 128'd0);
    check("mask_t1_busy",      128'(req_ready2), 128'd0);
    step();
    check("mask_t2_valid", 128'(rsp_valid2), 128'd1);
    check("mask_data",     128'(rsp_data2), 128'h8020_0003_9214_567B);
`ifdef MASK_SHARE_RVFI_EN
    check("mask_rvfi", 128'(rvfi2), 128'h8020_0003);
`endif
    step();
    check("mask_back_idle", 128'(req_ready2), 128'd1);

    // REMASK with LFSR at 0x80200003: r = 0xC0300002.
    issue2(2'b01, 64'h8020_0003_9214_567B);
    step();
    check("remask_valid", 128'(rsp_valid2), 128'd1);
    check("remask_data",  128'(rsp_data2), 128'h4010_0001_5224_5679);
    x = rsp_data2[63:32] ^ rsp_data2[31:0];
    check("remask_xor", 128'(x), 128'h1234_5678);
    step();

    // UNMASK: single-cycle, result at t+1.
    issue2(2'b10, 64'h4010_0001_5224_5679);
    check("unmask_valid_t1", 128'(rsp_valid2), 128'd1);
    check("unmask_data",     128'(rsp_data2), 128'h0000_0000_1234_5678);
    check("unmask_error",    128'(rsp_error2), 128'd0);
    step();

    // Illegal op under 5 cycles of backpressure.
    rsp_ready2 = 1'b0;
    issue2(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      check("illegal_valid", 128'(rsp_valid2), 128'd1);
      check("illegal_error", 128'(rsp_error2), 128'd1);
      check("illegal_data",  128'(rsp_data2),  128'd0);
      check("illegal_busy",  128'(req_ready2), 128'd0);
      step();
    end
    rsp_ready2 = 1'b1;
    step();
    check("illegal_released", 128'(req_ready2), 128'd1);

    // LFSR untouched by UNMASK/illegal: still 0xC0300002, next r = 0x60180001.
    issue2(2'b00, 64'h0);
    step();
    check("lfsr_kept_data", 128'(rsp_data2), 128'h6018_0001_6018_0001);
    step();

    // Reset while in GEN discards the operation and restores the LFSR.
    req_valid2 = 1'b1; req_op2 = 2'b00; req_data2 = 64'h0000_0000_1234_5678;
    step();
    req_valid2 = 1'b0;
    g_reset = 1'b1;
    step();
    check("rst_gen_valid", 128'(rsp_valid2), 128'd0);
    check("rst_gen_ready", 128'(req_ready2), 128'd1);
    g_reset = 1'b0;
    step();
    step();
    check("rst_no_response", 128'(rsp_valid2), 128'd0);
    issue2(2'b00, 64'h0000_0000_1234_5678);
    step();
    check("rst_lfsr_restored", 128'(rsp_data2), 128'h8020_0003_9214_567B);
    step();

    // 4-share MASK with a zero reseed between r1 and r2 (LFSR at reset value).
    req_valid4 = 1'b1; req_op4 = 2'b00; req_data4 = 128'h0000_0000_0000_0000_0000_0000_A5A5_A5A5;
    step();
    req_valid4 = 1'b0;
    step();
    seed_valid4 = 1'b1; seed4 = 32'h0;
    step();
    seed_valid4 = 1'b0;
    step();
    check("n4_not_yet_valid", 128'(rsp_valid4), 128'd0);
    step();
    check("n4_valid", 128'(rsp_valid4), 128'd1);
    check("n4_data", rsp_data4, 128'hC030_0002_8020_0003_8020_0003_6595_A5A7);
    x = rsp_data4[127:96] ^ rsp_data4[95:64] ^ rsp_data4[63:32] ^ rsp_data4[31:0];
    check("n4_xor", 128'(x), 128'hA5A5_A5A5);
`ifdef MASK_SHARE_RVFI_EN
    check("n4_rvfi", 128'(rvfi4), 128'hC030_0002_8020_0003_8020_0003);
`endif
    step();
    check("n4_back_idle", 128'(req_ready4), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mask_share_unit.md
Name: mask_share_unit

Overview:
- Multi-cycle, parametrised boolean-masking unit for the masking ISE.
- Generalises the fixed 2-share mask.b.mask to NSHARES shares, and adds REMASK and UNMASK modes.
- Fresh randomness comes from an internal reseedable Galois LFSR, one word per cycle.
- Sits beside the ALU in execute; uses valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, data/share width; 32 or 64 only.
- NSHARES, 2, number of boolean shares; legal range 2..4.
- PRNG_RESET, 32'h0000_0001 (zero-extended for XLEN=64), LFSR value after reset.

Ports:
- g_clk  in  1  clock
- g_reset  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_op  in  2  00 MASK, 01 REMASK, 10 UNMASK, 11 illegal
- req_data  in  XLEN*NSHARES  input shares; share i at [i*XLEN +: XLEN]; MASK uses share 0 only
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  XLEN*NSHARES  output shares, same packing as req_data
- rsp_error  out  1  illegal op flag
- prng_seed_valid  in  1  load prng_seed into LFSR
- prng_seed  in  XLEN  reseed value

Behaviour:
- Clock and reset: one clock (g_clk); reset is synchronous and active-high (g_reset).
- Reset values:
  - rsp_valid=0, rsp_error=0, rsp_data=0; req_ready=1 (next state IDLE).
  - LFSR=PRNG_RESET; share counter=0.
- FSM states:
  - IDLE: req_valid && req_ready latches op and shares.
    - MASK/REMASK -> GEN.
    - UNMASK/illegal -> DONE.
  - GEN: one LFSR step per cycle. Step value r_k (k=1..NSHARES-1) is applied as:
    - MASK: share_k := r_k; share_0 ^= r_k.
    - REMASK: share_k ^= r_k; share_0 ^= r_k.
    - After NSHARES-1 cycles -> DONE.
  - DONE: rsp_valid=1, rsp_data/rsp_error held stable until rsp_ready. On handshake -> IDLE.
- Latency, with accept at cycle t:
  - MASK/REMASK: rsp_valid at t+NSHARES.
  - UNMASK/illegal: rsp_valid at t+1.
  - Next request can be accepted no earlier than the cycle after the rsp handshake.
- UNMASK: share_0 = XOR of all input shares; shares 1..N-1 = 0; LFSR not stepped.
- Illegal op: rsp_error=1, rsp_data=0, LFSR not stepped.
- Invariant: XOR of all rsp_data shares equals the input secret (MASK) or the XOR of all input shares (REMASK).
- LFSR step: next = (s >> 1) ^ (s[0] ? POLY : 0).
  - POLY = 32'h8020_0003 for XLEN=32; 64'hD800_0000_0000_0000 for XLEN=64.
  - The stepped value is the r_k used in that cycle.
- Reseed:
  - prng_seed_valid loads the LFSR at the next edge and takes priority over a concurrent GEN step.
  - An in-flight GEN continues from the new seed.
  - A seed of 0 is loaded as 1 (avoids LFSR lockup).
- Backpressure: rsp_ready low in DONE holds all outputs and the LFSR unchanged.
- Reset mid-operation: GEN or DONE -> IDLE next cycle; rsp_valid drops; the pending result is discarded; the LFSR returns to PRNG_RESET.
- Unused share lanes of req_data for MASK are ignored.

Optional Feature:
- Macro: MASK_SHARE_RVFI_EN.
- When defined:
  - Adds output rvfi_mask_data, width XLEN*(NSHARES-1), holding r_1..r_{NSHARES-1} packed at [(k-1)*XLEN +: XLEN].
  - It is valid with rsp_valid and is zero for UNMASK/illegal.
  - Formal trace models use it to check share_k = r_k and share_0 = rs1 ^ XOR(r_k).
- When undefined: port and capture registers are absent; functional behaviour is identical.

Decomposition:
- Shared package mask_share_pkg:
  - op encodings (MASK_OP_MASK/REMASK/UNMASK);
  - FSM state typedef (IDLE/GEN/DONE);
  - POLY constants per XLEN;
  - share-slice helper function.
- One natural sub-module, mask_share_lfsr:
  - contains the LFSR register, step, reseed and zero-seed fix-up;
  - interface: step and load in; value and next out.

Test Plan:
- MASK, XLEN=32, NSHARES=2, seed 1, rs1=0x12345678 -> after 2 cycles rsp_data share1=0x80200003, share0=0x9214567B; rvfi_mask_data=0x80200003.
- REMASK immediately after (LFSR=0x80200003), shares {0x9214567B, 0x80200003} -> r=0xC0300002; share1=0x40100001, share0=0x52245679; XOR = 0x12345678.
- UNMASK {0x52245679, 0x40100001} -> rsp_valid at t+1, share0=0x12345678, share1=0; LFSR unchanged.
- Illegal op 2'b11 -> rsp_error=1, rsp_data=0 at t+1; hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0.
- NSHARES=4 MASK with prng_seed_valid=1 (seed 0) asserted mid-GEN -> LFSR loads 1, next r=0x80200003; XOR of 4 shares equals input.
- g_reset asserted in GEN -> next cycle rsp_valid=0, req_ready=1, LFSR=PRNG_RESET; no response emitted.
